// File: rtl/mac_rx_pktq.sv
// Receive packet queue: filters and stores MAC frames in a word RAM, keeps a
// queue of committed frame lengths and serves the head frame word by word.
module mac_rx_pktq #(
    parameter int          DEPTH_W  = 9,
    parameter int          NPKT_W   = 3,
    parameter int          MAX_LEN  = 1536,
    parameter logic [47:0] MAC_ADDR = 48'hfecafeca5000
) (
    input  logic        clk,
    input  logic        rstn,
    input  logic        in_valid,
    input  logic [31:0] in_data,
    input  logic [2:0]  in_nbyte,
    input  logic        in_last,
    input  logic        in_err,
    input  logic        en,
    input  logic        promisc,
    output logic        pkt_avail,
    output logic [10:0] pkt_len,
    input  logic        rd_req,
    output logic [31:0] rd_data,
    output logic        rd_valid,
    input  logic        pkt_drop,
    output logic [15:0] drop_cnt,
    input  logic        drop_clr
);
    localparam int AW = DEPTH_W + 1;
    localparam int NQ = 2 ** NPKT_W;
    localparam logic [11:0] MAX_L = 12'(MAX_LEN);
    // Wire byte 0 sits in in_data[7:0] and is the address MSB.
    localparam logic [31:0] MAC_W0 = {MAC_ADDR[23:16], MAC_ADDR[31:24], MAC_ADDR[39:32], MAC_ADDR[47:40]};
    localparam logic [15:0] MAC_W1 = {MAC_ADDR[7:0], MAC_ADDR[15:8]};

    typedef enum logic [1:0] {IDLE, RECV, SKIP, FAIL} rx_state_t;

    logic [31:0]       mem [2**DEPTH_W];
    logic [10:0]       lq [NQ];
    rx_state_t         state, state_nx;
    logic              synced, synced_nx;
    logic              hdr_pend, hdr_nx, hit0, hit_nx, bc0, bc_nx;
    logic [10:0]       len, len_nx, len_base;
    logic [11:0]       len_sum;
    logic [AW-1:0]     wptr, wptr_nx, fptr, fptr_nx, rptr, roff, used, nwords, raddr;
    logic [NPKT_W-1:0] lq_rd, lq_wr;
    logic [NPKT_W:0]   lq_cnt;
    logic              wr_en, push, pop, cnt_inc, take, ovf, filt_miss, addr_ok;
    logic              lq_full, commit_ok, rd_acc;

    assign used     = wptr - rptr;
    assign len_base = (state == IDLE) ? 11'd0 : len;
    assign len_sum  = {1'b0, len_base} + {9'd0, in_nbyte};
    assign addr_ok  = (hit0 && in_data[15:0] == MAC_W1) || (bc0 && in_data[15:0] == 16'hffff);
    assign lq_full  = lq_cnt[NPKT_W];
    assign pop      = pkt_drop && pkt_avail;

    assign pkt_avail = |lq_cnt;
    assign pkt_len   = pkt_avail ? lq[lq_rd] : 11'd0;
    assign nwords    = AW'(pkt_len[10:2]) + AW'(|pkt_len[1:0]);
    assign raddr     = rptr + roff;
    assign rd_acc    = rd_req && pkt_avail && !pkt_drop && (roff < nwords);

    // used[DEPTH_W] set means the RAM already holds 2**DEPTH_W unread words.
    assign ovf       = (len_sum > MAX_L) || used[DEPTH_W];
    assign filt_miss = (state == RECV) && hdr_pend && !promisc && !addr_ok;
    assign commit_ok = !in_err && !ovf && (len_sum >= 12'd14) && (!lq_full || pop);

    always_comb begin
        state_nx  = state;
        synced_nx = synced;
        hdr_nx    = hdr_pend;
        hit_nx    = hit0;
        bc_nx     = bc0;
        len_nx    = len;
        wptr_nx   = wptr;
        fptr_nx   = fptr;
        wr_en     = 1'b0;
        push      = 1'b0;
        cnt_inc   = 1'b0;
        take      = 1'b0;
        if (in_valid) begin
            case (state)
                IDLE: begin
                    if (!synced) begin
                        synced_nx = in_last;
                    end else if (!en) begin
                        if (!in_last) state_nx = SKIP;
                    end else begin
                        hit_nx = (in_data == MAC_W0);
                        bc_nx  = (in_data == 32'hffffffff);
                        take   = 1'b1;
                    end
                end
                RECV: begin
                    if (filt_miss) begin
                        wptr_nx  = fptr;
                        hdr_nx   = 1'b0;
                        state_nx = in_last ? IDLE : SKIP;
                    end else begin
                        take = 1'b1;
                    end
                end
                SKIP: if (in_last) state_nx = IDLE;
                FAIL: begin
                    if (in_last) begin
                        state_nx = IDLE;
                        wptr_nx  = fptr;
                        cnt_inc  = 1'b1;
                    end
                end
                default: state_nx = IDLE;
            endcase
            // The accepted first word is stored exactly like any RECV word.
            if (take) begin
                hdr_nx = (state == IDLE);
                if (!ovf) begin
                    wr_en   = 1'b1;
                    wptr_nx = wptr + AW'(1);
                    len_nx  = len_sum[10:0];
                end
                if (in_last) begin
                    state_nx = IDLE;
                    if (commit_ok) begin
                        push    = 1'b1;
                        fptr_nx = wptr + AW'(1);
                    end else begin
                        wptr_nx = fptr;
                        cnt_inc = 1'b1;
                    end
                end else begin
                    state_nx = ovf ? FAIL : RECV;
                end
            end
        end
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state    <= IDLE;
            synced   <= 1'b0;
            hdr_pend <= 1'b0;
            hit0     <= 1'b0;
            bc0      <= 1'b0;
            len      <= '0;
            wptr     <= '0;
            fptr     <= '0;
        end else begin
            state    <= state_nx;
            synced   <= synced_nx;
            hdr_pend <= hdr_nx;
            hit0     <= hit_nx;
            bc0      <= bc_nx;
            len      <= len_nx;
            wptr     <= wptr_nx;
            fptr     <= fptr_nx;
        end
    end

    always_ff @(posedge clk) begin
        if (wr_en) mem[wptr[DEPTH_W-1:0]] <= in_data;
        if (push) lq[lq_wr] <= len_sum[10:0];
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            rptr     <= '0;
            roff     <= '0;
            lq_rd    <= '0;
            lq_wr    <= '0;
            lq_cnt   <= '0;
            rd_valid <= 1'b0;
            rd_data  <= '0;
            drop_cnt <= '0;
        end else begin
            rd_valid <= rd_acc;
            if (rd_acc) rd_data <= mem[raddr[DEPTH_W-1:0]];
            if (pop) begin
                rptr  <= rptr + nwords;
                roff  <= '0;
                lq_rd <= lq_rd + 1'b1;
            end else if (rd_acc) begin
                roff <= roff + AW'(1);
            end
            if (push) lq_wr <= lq_wr + 1'b1;
            // Pop-then-push on a full queue leaves the count unchanged.
            if (push && !pop)      lq_cnt <= lq_cnt + 1'b1;
            else if (pop && !push) lq_cnt <= lq_cnt - 1'b1;
            if (drop_clr)                           drop_cnt <= '0;
            else if (cnt_inc && drop_cnt != 16'hffff) drop_cnt <= drop_cnt + 16'd1;
        end
    end
endmodule

// File: tb/tb_mac_rx_pktq.sv
// Bench for mac_rx_pktq: directed scenarios plus random frames against a
// frame-level queue model (packet lengths, stored words, drop count).
module tb_mac_rx_pktq;
    localparam int DEPTH_W = 6;
    localparam int NPKT_W  = 3;
    localparam int MAX_LEN = 200;
    localparam int RAM_WORDS = 1 << DEPTH_W;
    localparam int QMAX = 1 << NPKT_W;
    localparam logic [47:0] MAC   = 48'hfecafeca5000;
    localparam logic [47:0] BCAST = 48'hffffffffffff;
    localparam logic [47:0] OTHER = 48'h001122334455;

    logic        clk = 1'b0, rstn = 1'b0;
    logic        in_valid = 0, in_last = 0, in_err = 0, en = 0, promisc = 0;
    logic [31:0] in_data = '0;
    logic [2:0]  in_nbyte = '0;
    logic        pkt_avail, rd_valid;
    logic [10:0] pkt_len;
    logic [31:0] rd_data;
    logic        rd_req = 0, pkt_drop = 0, drop_clr = 0;
    logic [15:0] drop_cnt;

    int checks = 0, failures = 0, exp_cnt = 0;
    bit synced = 0, clr_on = 0;
    int mq_len[$];
    logic [31:0] mq_words[$];

    mac_rx_pktq #(.DEPTH_W(DEPTH_W), .NPKT_W(NPKT_W), .MAX_LEN(MAX_LEN), .MAC_ADDR(MAC)) dut (
        .clk(clk), .rstn(rstn), .in_valid(in_valid), .in_data(in_data), .in_nbyte(in_nbyte),
        .in_last(in_last), .in_err(in_err), .en(en), .promisc(promisc),
        .pkt_avail(pkt_avail), .pkt_len(pkt_len), .rd_req(rd_req), .rd_data(rd_data),
        .rd_valid(rd_valid), .pkt_drop(pkt_drop), .drop_cnt(drop_cnt), .drop_clr(drop_clr)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic check_state(input string tag);
        check({tag, ".avail"}, pkt_avail, mq_len.size() != 0);
        check({tag, ".len"}, pkt_len, mq_len.size() != 0 ? mq_len[0] : 0);
        check({tag, ".drop_cnt"}, drop_cnt, exp_cnt);
    endtask

    task automatic pop_head();
        int n;
        if (mq_len.size() == 0) return;
        n = (mq_len[0] + 3) / 4;
        void'(mq_len.pop_front());
        repeat (n) void'(mq_words.pop_front());
    endtask

    task automatic send_frame(input int nb, input logic [47:0] dst, input bit e, input bit pr,
                              input bit err, input bit drop_last);
        int nw, used;
        bit ign, drp;
        logic [7:0] b[$];
        logic [31:0] words[$];
        nw = (nb + 3) / 4;
        used = mq_words.size();
        ign = 0;
        drp = 0;
        for (int i = 0; i < nw * 4 || i < 8; i++) b.push_back(8'($urandom));
        for (int i = 0; i < 6; i++) b[i] = dst[47-8*i -: 8];
        if (!synced || !e) ign = 1;
        else if (used >= RAM_WORDS) drp = 1;
        else if (nw >= 2 && !pr && dst != MAC && dst != BCAST) ign = 1;
        else if (err || nb > MAX_LEN || used + nw > RAM_WORDS || nb < 14 ||
                 (mq_len.size() == QMAX && !drop_last)) drp = 1;
        for (int w = 0; w < nw; w++) begin
            in_valid = 1;
            in_data  = {b[4*w+3], b[4*w+2], b[4*w+1], b[4*w]};
            in_nbyte = (w == nw - 1) ? 3'(nb - 4 * w) : 3'd4;
            in_last  = (w == nw - 1);
            in_err   = err && in_last;
            en       = (w == 0) ? e : !e;
            promisc  = pr;
            pkt_drop = drop_last && in_last;
            words.push_back(in_data);
            tick();
        end
        in_valid = 0; in_last = 0; in_err = 0; pkt_drop = 0; en = 1;
        if (drop_last) pop_head();
        if (!ign && !drp) begin
            mq_len.push_back(nb);
            foreach (words[i]) mq_words.push_back(words[i]);
        end
        if (clr_on) exp_cnt = 0;
        else if (drp && exp_cnt < 65535) exp_cnt++;
        synced = 1;
        check_state("frame");
    endtask

    task automatic read_head(input int k);
        int nw;
        nw = (mq_len[0] + 3) / 4;
        for (int i = 0; i < k; i++) begin
            rd_req = 1;
            tick();
            check("rd_valid", rd_valid, 1);
            check("rd_data", rd_data, mq_words[i]);
        end
        if (k == nw) begin
            rd_req = 1;
            tick();
            check("rd_past_end", rd_valid, 0);
        end
        rd_req = 0;
    endtask

    task automatic drop_head();
        pkt_drop = 1;
        tick();
        pkt_drop = 0;
        pop_head();
        check_state("drop");
    endtask

    task automatic drain();
        while (mq_len.size() > 0) begin
            read_head((mq_len[0] + 3) / 4);
            drop_head();
        end
    endtask

    task automatic check_reset(input string tag);
        check({tag, ".avail"}, pkt_avail, 0);
        check({tag, ".len"}, pkt_len, 0);
        check({tag, ".rd_data"}, rd_data, 0);
        check({tag, ".rd_valid"}, rd_valid, 0);
        check({tag, ".drop_cnt"}, drop_cnt, 0);
    endtask

    initial begin
        int nb, k, act;
        logic [47:0] dst;
        tick();
        tick();
        check_reset("reset");
        rstn = 1;
        tick();

        // First frame after reset only resynchronises.
        send_frame(64, MAC, 1, 0, 0, 0);
        send_frame(64, MAC, 1, 0, 0, 0);
        check("unicast_len", pkt_len, 64);
        read_head(16);
        drop_head();
        rd_req = 1;
        tick();
        check("rd_empty", rd_valid, 0);
        rd_req = 0;
        drop_head();

        send_frame(64, OTHER, 1, 0, 0, 0);
        send_frame(64, OTHER, 1, 1, 0, 0);
        drain();
        send_frame(64, MAC, 0, 0, 0, 0);

        send_frame(61, BCAST, 1, 0, 1, 0);
        send_frame(61, BCAST, 1, 0, 0, 0);
        read_head(16);
        drop_head();

        // RAM space: 28+28 fills 56 of 64 words; exact fit commits.
        send_frame(112, MAC, 1, 0, 0, 0);
        send_frame(112, MAC, 1, 0, 0, 0);
        send_frame(112, MAC, 1, 0, 0, 0);
        send_frame(32, MAC, 1, 0, 0, 0);
        read_head(5);
        drop_head();
        send_frame(112, MAC, 1, 0, 0, 0);
        send_frame(14, MAC, 1, 0, 0, 0);
        drain();

        send_frame(MAX_LEN, MAC, 1, 0, 0, 0);
        drain();
        send_frame(MAX_LEN + 1, MAC, 1, 0, 0, 0);
        send_frame(13, MAC, 1, 0, 0, 0);
        send_frame(14, MAC, 1, 0, 0, 0);
        drain();

        // Length queue full, then pop and push in the same cycle.
        for (int i = 0; i < QMAX; i++) send_frame(14 + i, MAC, 1, 0, 0, 0);
        send_frame(14, MAC, 1, 0, 0, 0);
        send_frame(30, MAC, 1, 0, 0, 1);
        check("qfull_count", mq_len.size(), QMAX);
        drain();

        for (int it = 0; it < 40; it++) begin
            k = $urandom_range(0, 9);
            dst = (k < 6) ? MAC : (k < 8) ? BCAST : OTHER;
            nb = $urandom_range(8, MAX_LEN + 10);
            send_frame(nb, dst, $urandom_range(0, 9) != 0, $urandom_range(0, 3) == 0,
                       $urandom_range(0, 7) == 0, 0);
            act = $urandom_range(0, 3);
            if (mq_len.size() > 0 && act == 0) begin
                read_head((mq_len[0] + 3) / 4);
                drop_head();
            end else if (mq_len.size() > 0 && act == 1) begin
                read_head($urandom_range(0, (mq_len[0] + 3) / 4 - 1));
                drop_head();
            end
        end
        drain();

        // Reset in the middle of a frame.
        send_frame(40, MAC, 1, 0, 0, 0);
        for (int w = 0; w < 5; w++) begin
            in_valid = 1; in_data = $urandom; in_nbyte = 4; en = 1;
            tick();
        end
        in_valid = 0;
        rstn = 0;
        #1;
        check_reset("midreset");
        mq_len.delete();
        mq_words.delete();
        exp_cnt = 0;
        synced = 0;
        tick();
        rstn = 1;
        send_frame(40, MAC, 1, 0, 0, 0);
        send_frame(40, MAC, 1, 0, 0, 0);
        drain();

        send_frame(20, MAC, 1, 0, 1, 0);
        clr_on = 1;
        drop_clr = 1;
        send_frame(20, MAC, 1, 0, 1, 0);
        drop_clr = 0;
        clr_on = 0;

        // Back-to-back one-word errored frames drive the counter to saturation.
        in_valid = 1; in_last = 1; in_err = 1; en = 1; in_nbyte = 4; in_data = $urandom;
        for (int i = 0; i < 65534; i++) begin
            tick();
            if (exp_cnt < 65535) exp_cnt++;
        end
        check("cnt_fffe", drop_cnt, exp_cnt);
        for (int i = 0; i < 2; i++) begin
            tick();
            if (exp_cnt < 65535) exp_cnt++;
            check("cnt_sat", drop_cnt, exp_cnt);
        end
        in_valid = 0; in_last = 0; in_err = 0;
        drop_clr = 1;
        tick();
        drop_clr = 0;
        exp_cnt = 0;
        check("cnt_clr", drop_cnt, exp_cnt);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
